// File: rtl/alu_issue_stage.sv
// Decode/operand-read issue stage: one output register (1-cycle issue latency); in_ready drops on output backpressure or pending branch.
// Optional write-back forwarding on same-cycle register reads is enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_operation,
  output logic [DATA_W-1:0] out_readData0,
  output logic [DATA_W-1:0] out_readData1,
  output logic [3:0]        out_rd,
  output logic              out_is_branch,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              br_done,
  input  logic              br_taken,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              illegal
);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic              out_valid_q;
  logic [3:0]        out_op_q;
  logic [3:0]        out_rd_q;
  logic [DATA_W-1:0] out_d0_q;
  logic [DATA_W-1:0] out_d1_q;
  logic              out_br_q;
  logic              illegal_q;
  logic              redir_vld_q;
  logic [DATA_W-1:0] redir_pc_q;
  logic [DATA_W-1:0] target_q;

  logic [3:0]        opcode;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic              accept;
  logic              legal;
  logic              is_br;
  logic              uses_rt;
  logic [DATA_W-1:0] rd0_d;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] target_d;

  assign opcode   = in_instr[15:12];
  assign rs       = in_instr[7:4];
  assign rt       = in_instr[3:0];
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign legal    = (opcode <= 4'd8);
  assign is_br    = legal && (opcode >= 4'd4);
  assign uses_rt  = (opcode == 4'd0) || (opcode == 4'd1) || (opcode == 4'd4) ||
                    (opcode == 4'd7) || (opcode == 4'd8);
  // Branch target is computed at accept time so BR_WAIT only needs the resolved outcome.
  assign target_d = in_pc + {{(DATA_W-4){in_instr[11]}}, in_instr[11:8]};

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 4'(i)) val = rf_q[i];
    end
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_en && (wb_addr == idx)) val = wb_data;
`endif
    return val;
  endfunction

  always_comb begin
    rd0_d = rf_read(rs);
    rd1_d = uses_rt ? rf_read(rt) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_d0_q    <= '0;
      out_d1_q    <= '0;
      out_br_q    <= 1'b0;
      illegal_q   <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      target_q    <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == 4'(i))) rf_q[i] <= wb_data;
      end
      illegal_q   <= accept && !legal;
      redir_vld_q <= 1'b0;
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_op_q    <= opcode;
        out_rd_q    <= in_instr[11:8];
        out_d0_q    <= rd0_d;
        out_d1_q    <= rd1_d;
        out_br_q    <= is_br;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (accept && is_br) begin
            state_q  <= BR_WAIT;
            target_q <= target_d;
          end
        end
        BR_WAIT: begin
          if (br_done) begin
            state_q <= RUN;
            if (br_taken) begin
              redir_vld_q <= 1'b1;
              redir_pc_q  <= target_q;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_operation  = out_op_q;
  assign out_readData0  = out_d0_q;
  assign out_readData1  = out_d1_q;
  assign out_rd         = out_rd_q;
  assign out_is_branch  = out_br_q;
  assign illegal        = illegal_q;
  assign redirect_valid = redir_vld_q;
  assign redirect_pc    = redir_pc_q;

endmodule
